sequencer_fsa: RTL and testbench



---
 rtl/sequencer_fsa_if.sv | 23 ++
 rtl/sequencer_fsa.sv | 120 ++++++++++++
 tb/tb_sequencer_fsa.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequencer_fsa_if.sv
// Handshake bundle between the run controls/decoder and the FSA sequencer.
// The master side drives the controls; the slave side (sequencer) returns the step word and strobes.
interface sequencer_fsa_if;
  logic       run;
  logic       single;
  logic       halt_req;
  logic [2:0] len_code;
  logic [7:0] fsa_out;
  logic       ir_load;
  logic       pc_inc;
  logic       inst_done;
  logic       halted;

  modport master (
    output run, single, halt_req, len_code,
    input  fsa_out, ir_load, pc_inc, inst_done, halted
  );

  modport slave (
    input  run, single, halt_req, len_code,
    output fsa_out, ir_load, pc_inc, inst_done, halted
  );
endinterface

// File: rtl/sequencer_fsa.sv
// FSA step generator: fetch steps 0..7, then execute up to the decoder-selected length,
// then wrap to fetch or halt. Outputs are decoded from registered state.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   HALTED  | idle, all outputs low except halted; run=1 starts a fetch
//   FETCH   | steps 0..FETCH_LAST, ir_load/pc_inc strobes, length latched at end
//   EXEC    | steps 8..len_q-1, decoder executes the instruction
module sequencer_fsa #(
  parameter int IR_LOAD_STEP = 5,
  parameter int PC_INC_STEP  = 6,
  parameter int FETCH_LAST   = 7
) (
  input  logic           clock,
  input  logic           reset,
  sequencer_fsa_if.slave bus
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  localparam logic [4:0] IR_STEP    = 5'(IR_LOAD_STEP);
  localparam logic [4:0] PC_STEP    = 5'(PC_INC_STEP);
  localparam logic [4:0] LAST_FETCH = 5'(FETCH_LAST);
  localparam logic [4:0] EXEC_FIRST = 5'd8;
  localparam logic [4:0] STEP_MAX   = 5'd23;

  state_t     state_q, state_d;
  logic [4:0] step_q, step_d;
  logic [4:0] len_q, len_d;
  logic [4:0] code_len;
  logic       final_step;
  logic       in_fetch;
  logic       in_exec;
  logic       ir_load_c;
  logic       pc_inc_c;

  always_comb begin
    code_len = 5'd8;
    case (bus.len_code)
      3'd1:    code_len = 5'd10;
      3'd2:    code_len = 5'd12;
      3'd3:    code_len = 5'd14;
      3'd4:    code_len = 5'd24;
      default: code_len = 5'd8;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_HALTED;
      step_q  <= 5'd0;
      len_q   <= 5'd8;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    final_step = 1'b0;
    in_fetch   = 1'b0;
    in_exec    = 1'b0;
    ir_load_c  = 1'b0;
    pc_inc_c   = 1'b0;

    case (state_q)
      S_HALTED: begin
        step_d = 5'd0;
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        in_fetch  = 1'b1;
        ir_load_c = (step_q == IR_STEP);
        pc_inc_c  = (step_q == PC_STEP);
        if (step_q == LAST_FETCH) begin
          // Length is taken from the decoder on this step only.
          len_d = code_len;
          if (code_len == 5'd8) begin
            final_step = 1'b1;
          end else begin
            state_d = S_EXEC;
            step_d  = EXEC_FIRST;
          end
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      S_EXEC: begin
        in_exec = 1'b1;
        if ((step_q == len_q - 5'd1) || (step_q >= STEP_MAX)) final_step = 1'b1;
        else step_d = step_q + 5'd1;
      end
      default: begin
        state_d = S_HALTED;
        step_d  = 5'd0;
      end
    endcase

    if (final_step) begin
      step_d = 5'd0;
      if (bus.halt_req || bus.single || !bus.run) state_d = S_HALTED;
      else state_d = S_FETCH;
    end
  end

  assign bus.fsa_out   = (state_q == S_HALTED) ? 8'h00 : {final_step, in_exec, in_fetch, step_q};
  assign bus.ir_load   = ir_load_c;
  assign bus.pc_inc    = pc_inc_c;
  assign bus.inst_done = final_step;
  assign bus.halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_sequencer_fsa.sv
// Directed bench for sequencer_fsa: each task drives one scenario and checks the packed
// output word {fsa_out, ir_load, pc_inc, inst_done, halted} every cycle.
module tb_sequencer_fsa;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [11:0] obs;
  logic [11:0] exp_v;

  localparam logic [11:0] HALTED_VEC = 12'h001;

  sequencer_fsa_if bus ();

  sequencer_fsa dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output word for step s of an instruction of total length len.
  function automatic logic [11:0] exp_vec(input int s, input int len);
    logic [7:0] f;
    logic       fin;
    f   = 8'(s) | ((s < 8) ? 8'h20 : 8'h40);
    fin = (s == len - 1);
    if (fin) f = f | 8'h80;
    return {f, (s == 5), (s == 6), fin, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.single   = 1'b0;
    bus.halt_req = 1'b0;
    bus.len_code = 3'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.run      = 1'b1;
    bus.single   = 1'b0;
    bus.halt_req = 1'b0;
    bus.len_code = 3'd0;
    tick();
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, HALTED_VEC);
    end
    bus.run = 1'b0;
    reset   = 1'b0;
    tick();
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL reset_idle_run0: got %h expected %h", obs, HALTED_VEC);
    end
  endtask

  task automatic test_len8();
    int dones;
    do_reset();
    dones        = 0;
    bus.len_code = 3'd0;
    bus.run      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.inst_done) dones++;
      exp_v = exp_vec(i % 8, 8);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL len8 cycle %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    n_checks++;
    if (dones !== 3) begin
      n_fail++;
      $display("FAIL len8_done_count: got %0d expected 3", dones);
    end
  endtask

  task automatic test_len24();
    do_reset();
    bus.len_code = 3'd4;
    bus.run      = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      exp_v = exp_vec(i % 24, 24);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL len24 cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 23) begin
        n_checks++;
        if (bus.fsa_out !== 8'hD7) begin
          n_fail++;
          $display("FAIL len24_last_word: got %h expected d7", bus.fsa_out);
        end
      end
    end
  endtask

  task automatic test_len_change();
    do_reset();
    bus.len_code = 3'd2;
    bus.run      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = exp_vec(i, 12);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL len_change step %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 9) bus.len_code = 3'd4;
    end
    tick();
    exp_v = exp_vec(0, 24);
    obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL len_change_wrap: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_halt_req();
    do_reset();
    bus.len_code = 3'd1;
    bus.run      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_v = exp_vec(i, 10);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL halt_req step %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 2) bus.halt_req = 1'b1;
    end
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL halt_req_halted: got %h expected %h", obs, HALTED_VEC);
    end
    bus.halt_req = 1'b0;
    tick();
    exp_v = exp_vec(0, 10);
    obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL halt_req_resume: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.len_code = 3'd3;
    bus.single   = 1'b1;
    bus.run      = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_v = exp_vec(i, 14);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_first step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL single_halt: got %h expected %h", obs, HALTED_VEC);
    end
    bus.run = 1'b0;
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL single_run_low: got %h expected %h", obs, HALTED_VEC);
    end
    bus.run = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_v = exp_vec(i, 14);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_second step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL single_halt_again: got %h expected %h", obs, HALTED_VEC);
    end
    bus.single = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.len_code = 3'd4;
    bus.run      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_v = exp_vec(i, 24);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    reset = 1'b1;
    tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %h expected %h", obs, HALTED_VEC);
    end
    reset = 1'b0;
    tick();
    exp_v = exp_vec(0, 24);
    obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_len_code6();
    do_reset();
    bus.len_code = 3'd6;
    bus.run      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_v = exp_vec(i % 8, 8);
      obs   = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL len_code6 cycle %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    bus.run = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    obs = {bus.fsa_out, bus.ir_load, bus.pc_inc, bus.inst_done, bus.halted};
    n_checks++;
    if (obs !== HALTED_VEC) begin
      n_fail++;
      $display("FAIL run_low_stop: got %h expected %h", obs, HALTED_VEC);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.single   = 1'b0;
    bus.halt_req = 1'b0;
    bus.len_code = 3'd0;
    test_reset();
    test_len8();
    test_len24();
    test_len_change();
    test_halt_req();
    test_single();
    test_reset_mid();
    test_len_code6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
